// File: rtl/stack_mips_controller.sv
// Multi-cycle Moore control FSM for the 8-bit stack-based MIPS datapath.
// Sequences PC, memory, IR, stack, A/B and ALU strobes from the IR opcode.
module stack_mips_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opc,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       pcsrc,
  output logic       PorI,
  output logic       memread,
  output logic       memwrite,
  output logic       IRwrite,
  output logic       MtoS,
  output logic       ldA,
  output logic       ldB,
  output logic       srcA,
  output logic       srcB,
  output logic       push,
  output logic       pop,
  output logic       tos,
  output logic [1:0] ALUop,
  output logic [3:0] state
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_PUSH = 3'b100;
  localparam logic [2:0] OP_POP  = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_JZ   = 3'b111;

  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_POPA  = 4'd2,
    S_POPB  = 4'd3,
    S_EXE   = 4'd4,
    S_PUSHR = 4'd5,
    S_MEMRD = 4'd6,
    S_PUSHM = 4'd7,
    S_POPM  = 4'd8,
    S_MEMWR = 4'd9,
    S_JMP   = 4'd10,
    S_JZT   = 4'd11
  } state_e;

  // Kept as a plain vector so the unused codes 12-15 remain representable.
  logic [3:0] state_q;
  state_e     state_d;

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:    state_d = S_ID;
      S_ID: begin
        case (opc)
          OP_ADD, OP_SUB, OP_AND, OP_NOT: state_d = S_POPA;
          OP_PUSH: state_d = S_MEMRD;
          OP_POP:  state_d = S_POPM;
          OP_JMP:  state_d = S_JMP;
          OP_JZ:   state_d = S_JZT;
          default: state_d = S_IF;
        endcase
      end
      S_POPA:  state_d = (opc == OP_NOT) ? S_EXE : S_POPB;
      S_POPB:  state_d = S_EXE;
      S_EXE:   state_d = S_PUSHR;
      S_MEMRD: state_d = S_PUSHM;
      S_POPM:  state_d = S_MEMWR;
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  // Strobes are decoded from the state register and held low during reset.
  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    pcsrc       = 1'b0;
    PorI        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    IRwrite     = 1'b0;
    MtoS        = 1'b0;
    ldA         = 1'b0;
    ldB         = 1'b0;
    srcA        = 1'b0;
    srcB        = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    tos         = 1'b0;
    ALUop       = 2'b00;
    state       = rst ? 4'd0 : state_q;
    if (!rst) begin
      case (state_q)
        S_IF: begin
          memread = 1'b1;
          IRwrite = 1'b1;
          srcA    = 1'b1;
          srcB    = 1'b1;
          pcwrite = 1'b1;
        end
        S_POPA, S_POPM: begin
          tos = 1'b1;
          ldA = 1'b1;
          pop = 1'b1;
        end
        S_POPB: begin
          tos = 1'b1;
          ldB = 1'b1;
          pop = 1'b1;
        end
        // Opcode low bits map directly onto the ALU op encoding.
        S_EXE:   ALUop = opc[1:0];
        S_PUSHR: push = 1'b1;
        S_MEMRD: begin
          memread = 1'b1;
          PorI    = 1'b1;
        end
        S_PUSHM: begin
          MtoS = 1'b1;
          push = 1'b1;
        end
        S_MEMWR: begin
          memwrite = 1'b1;
          PorI     = 1'b1;
        end
        S_JMP: begin
          pcsrc   = 1'b1;
          pcwrite = 1'b1;
        end
        S_JZT: begin
          tos         = 1'b1;
          pcsrc       = 1'b1;
          pcwritecond = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
